fpu_req_sequencer: RTL and testbench

Initiator/master side of the FP operation interface: queues operation commands from a producer and issues them one at a time to the FP unit (a, b, opcode, start). It waits for the unit's done flag, captures the result and returns it on a valid/ready response channel. It sits between the test/control logic and the FP top, replacing ad-hoc opcode/start driving.

---
 rtl/fpu_req_sequencer_pkg.sv | 28 ++
 rtl/fpu_req_sequencer_cmd_fifo.sv | 56 +++++
 rtl/fpu_req_sequencer.sv | 154 +++++++++++++++
 tb/tb_fpu_req_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_req_sequencer_pkg.sv
// Shared types for the FP request sequencer: opcodes, sequencer states and
// the command record stored in the command FIFO.
package fpu_pkg;

   // Width of the command record operands; the sequencer's W tracks this.
   localparam int FPU_W = 32;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_MUL = 2'b01,
      OP_DIV = 2'b10,
      OP_RSV = 2'b11
   } fpu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } seq_state_t;

   typedef struct packed {
      fpu_op_t            opcode;
      logic [FPU_W-1:0]   a;
      logic [FPU_W-1:0]   b;
   } fpu_cmd_t;

endpackage

// File: rtl/fpu_req_sequencer_cmd_fifo.sv
// Command FIFO for the FP request sequencer. Pointers carry one extra wrap
// bit so full and empty are told apart without a separate count.
// Push into a full FIFO and pop from an empty one are silently dropped.
module fpu_cmd_fifo
   import fpu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     push,
   input  fpu_cmd_t push_data,
   input  logic     pop,
   output fpu_cmd_t pop_data,
   output logic     full,
   output logic     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        do_push, do_pop;
   fpu_cmd_t    mem_q [DEPTH];

   // Status flags and pointer advance.
   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
      pop_data = mem_q[rd_ptr_q[AW-1:0]];
   end

   // Pointer registers; reset empties the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage; contents are meaningless until written, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/fpu_req_sequencer.sv
// FP request sequencer: queues commands, issues them one at a time to the FP
// unit with a one-cycle start pulse, waits for done (or times out) and hands
// the result back on a valid/ready response channel.
// Optional: define FPU_DIV0_CHECK_EN to reject div with b==0 without issuing.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. cmd_ready depends only on FIFO state; rsp_valid and rsp_* stay
// stable until the edge where rsp_ready is seen high.
module fpu_req_sequencer
   import fpu_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64,
   parameter int W       = FPU_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [1:0]   cmd_opcode,
   input  logic [W-1:0] cmd_a,
   input  logic [W-1:0] cmd_b,
   output logic [W-1:0] fpu_a,
   output logic [W-1:0] fpu_b,
   output logic [1:0]   fpu_opcode,
   output logic         fpu_start,
   input  logic [W-1:0] fpu_result,
   input  logic         fpu_done,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_data,
   output logic [1:0]   rsp_opcode,
   output logic         rsp_err,
   output logic [1:0]   dbg_state
);

   localparam int CW = $clog2(TIMEOUT);

   seq_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0] fpu_a_q, fpu_a_d;
   logic [W-1:0] fpu_b_q, fpu_b_d;
   fpu_op_t      fpu_op_q, fpu_op_d;
   logic [W-1:0] rsp_data_q, rsp_data_d;
   logic         rsp_err_q, rsp_err_d;

   fpu_cmd_t     fifo_wr, fifo_rd;
   logic         fifo_full, fifo_empty, fifo_pop, reject;

   assign fifo_wr = '{opcode: fpu_op_t'(cmd_opcode), a: cmd_a, b: cmd_b};

   fpu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (cmd_valid && cmd_ready),
      .push_data(fifo_wr),
      .pop      (fifo_pop),
      .pop_data (fifo_rd),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // Next-state and datapath: pop in IDLE, pulse in ISSUE, watch done or
   // the timeout in WAIT, hold the response in RESP.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      fpu_a_d    = fpu_a_q;
      fpu_b_d    = fpu_b_q;
      fpu_op_d   = fpu_op_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      fifo_pop   = 1'b0;
      reject     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               fpu_a_d  = fifo_rd.a;
               fpu_b_d  = fifo_rd.b;
               fpu_op_d = fifo_rd.opcode;
               if (fifo_rd.opcode == OP_RSV) reject = 1'b1;
`ifdef FPU_DIV0_CHECK_EN
               if ((fifo_rd.opcode == OP_DIV) && (fifo_rd.b == '0)) reject = 1'b1;
`endif
               if (reject) begin
                  rsp_data_d = '0;
                  rsp_err_d  = 1'b1;
                  state_d    = ST_RESP;
               end else begin
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (fpu_done) begin
               rsp_data_d = fpu_result;
               rsp_err_d  = 1'b0;
               state_d    = ST_RESP;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               rsp_data_d = '0;
               rsp_err_d  = 1'b1;
               state_d    = ST_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset drops any in-flight op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         fpu_a_q    <= '0;
         fpu_b_q    <= '0;
         fpu_op_q   <= OP_ADD;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         fpu_a_q    <= fpu_a_d;
         fpu_b_q    <= fpu_b_d;
         fpu_op_q   <= fpu_op_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   // Outputs are decoded straight from registered state.
   always_comb begin
      cmd_ready  = !fifo_full;
      fpu_a      = fpu_a_q;
      fpu_b      = fpu_b_q;
      fpu_opcode = fpu_op_q;
      fpu_start  = (state_q == ST_ISSUE);
      rsp_valid  = (state_q == ST_RESP);
      rsp_data   = rsp_data_q;
      rsp_opcode = fpu_op_q;
      rsp_err    = rsp_err_q;
      dbg_state  = state_q;
   end

endmodule

// File: tb/tb_fpu_req_sequencer.sv
// Testbench for fpu_req_sequencer: a behavioural FP unit model plus
// per-scenario tasks comparing responses against expected queues.
module tb_fpu_req_sequencer;
   import fpu_pkg::*;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 16;
   localparam int W       = 32;

   logic         clk, rst_n;
   logic         cmd_valid, cmd_ready;
   logic [1:0]   cmd_opcode;
   logic [W-1:0] cmd_a, cmd_b;
   logic [W-1:0] fpu_a, fpu_b, fpu_result;
   logic [1:0]   fpu_opcode;
   logic         fpu_start, fpu_done;
   logic         rsp_valid, rsp_ready, rsp_err;
   logic [W-1:0] rsp_data;
   logic [1:0]   rsp_opcode, dbg_state;

   int n_pass, n_total;
   int cyc, start_cnt;
   int cd, fpu_lat;
   bit hang;
   logic [W-1:0] res_pend;

   logic [W-1:0] exp_q[$];
   logic         exp_err_q[$];
   logic [1:0]   exp_op_q[$];

   fpu_req_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .W(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_opcode(fpu_opcode), .fpu_start(fpu_start),
      .fpu_result(fpu_result), .fpu_done(fpu_done),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_opcode(rsp_opcode), .rsp_err(rsp_err), .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial start_cnt = 0;
   always @(negedge clk) if (fpu_start === 1'b1) start_cnt = start_cnt + 1;

   // Arithmetic the FP unit model computes.
   function automatic logic [W-1:0] unit_result(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
      case (op)
         2'b00:   return a + b;
         2'b01:   return a * b;
         2'b10:   return (b == 0) ? '1 : a / b;
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   // Expected response for a command given the unit never hangs.
   task automatic expect_rsp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      bit err;
      err = (op == 2'b11);
`ifdef FPU_DIV0_CHECK_EN
      if (op == 2'b10 && b == 0) err = 1'b1;
`endif
      exp_q.push_back(err ? '0 : unit_result(op, a, b));
      exp_err_q.push_back(err);
      exp_op_q.push_back(op);
   endtask

   // FP unit model: done pulses fpu_lat cycles after start (random 1..5 when 0).
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cd = 0;
         fpu_done = 1'b0;
         fpu_result = '0;
      end else begin
         fpu_done = 1'b0;
         if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0) begin
               fpu_done = 1'b1;
               fpu_result = res_pend;
            end
         end
         if (fpu_start === 1'b1 && !hang) begin
            cd = (fpu_lat == 0) ? int'($urandom_range(1, 5)) : fpu_lat;
            res_pend = unit_result(fpu_opcode, fpu_a, fpu_b);
         end
      end
   end

   // driver: offer one command, push occurs on the following rising edge
   task automatic push_cmd(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!cmd_ready && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      n_total++;
      if (!cmd_ready) begin
         $display("FAIL push_wait: cmd_ready=%b required 1", cmd_ready);
         return;
      end
      n_pass++;
      cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   // driver: wait for a response and accept it
   task automatic wait_rsp(output bit ok, output logic [W-1:0] d, output logic e, output logic [1:0] o);
      int guard;
      ok = 0; d = '0; e = 1'b0; o = 2'b00;
      guard = 0;
      @(negedge clk);
      while (!rsp_valid && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      n_total++;
      if (!rsp_valid) begin
         $display("FAIL rsp_wait: rsp_valid=%b required 1", rsp_valid);
         return;
      end
      n_pass++;
      ok = 1; d = rsp_data; e = rsp_err; o = rsp_opcode;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   task automatic check_rsp(input string name, input logic [W-1:0] d, input logic e, input logic [1:0] o,
                            input logic [W-1:0] xd, input logic xe, input logic [1:0] xo);
      n_total++;
      if (d !== xd || e !== xe || o !== xo)
         $display("FAIL %s: data=%h err=%b op=%b required data=%h err=%b op=%b", name, d, e, o, xd, xe, xo);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = 2'b00; cmd_a = '0; cmd_b = '0;
      rsp_ready = 1'b0; hang = 0; fpu_lat = 0;
      repeat (3) @(negedge clk);
      n_total++;
      if ({rsp_valid, fpu_start, rsp_err, fpu_opcode, rsp_opcode, dbg_state} !== 9'b0 || fpu_a !== '0 || fpu_b !== '0 || rsp_data !== '0)
         $display("FAIL reset_outputs: valid=%b start=%b err=%b a=%h data=%h required all 0", rsp_valid, fpu_start, rsp_err, fpu_a, rsp_data);
      else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
      n_total++;
      if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready);
      else n_pass++;
   endtask

   task automatic test_add();
      fpu_lat = 3;
      push_cmd(2'b00, 32'h3, 32'h4);
      // push was at edge N; the k-th falling edge after it lies in cycle N+k
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         n_total++;
         if (fpu_start !== (k == 2)) $display("FAIL add_start_c%0d: got %b required %b", k, fpu_start, (k == 2));
         else n_pass++;
         n_total++;
         if (rsp_valid !== (k == 6)) $display("FAIL add_rsp_valid_c%0d: got %b required %b", k, rsp_valid, (k == 6));
         else n_pass++;
      end
      check_rsp("add_rsp", rsp_data, rsp_err, rsp_opcode, 32'h7, 1'b0, 2'b00);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      fpu_lat = 0;
   endtask

   task automatic test_reserved();
      bit ok; logic [W-1:0] d; logic e; logic [1:0] o; int s0;
      s0 = start_cnt;
      push_cmd(2'b11, 32'h1, 32'h2);
      wait_rsp(ok, d, e, o);
      if (ok) check_rsp("reserved_rsp", d, e, o, '0, 1'b1, 2'b11);
      n_total++;
      if (start_cnt !== s0) $display("FAIL reserved_no_start: starts=%0d required %0d", start_cnt - s0, 0);
      else n_pass++;
   endtask

   task automatic test_div0();
      bit ok; logic [W-1:0] d; logic e; logic [1:0] o; int s0, xs;
      s0 = start_cnt;
      push_cmd(2'b10, 32'h8, 32'h0);
      wait_rsp(ok, d, e, o);
`ifdef FPU_DIV0_CHECK_EN
      if (ok) check_rsp("div0_rsp", d, e, o, '0, 1'b1, 2'b10);
      xs = 0;
`else
      if (ok) check_rsp("div0_rsp", d, e, o, '1, 1'b0, 2'b10);
      xs = 1;
`endif
      n_total++;
      if (start_cnt - s0 !== xs) $display("FAIL div0_starts: got %0d required %0d", start_cnt - s0, xs);
      else n_pass++;
   endtask

   task automatic test_timeout();
      bit ok; logic [W-1:0] d; logic e; logic [1:0] o; int s, r, g, s0;
      s0 = start_cnt;
      hang = 1;
      push_cmd(2'b10, 32'h8, 32'h2);
      push_cmd(2'b00, 32'h1, 32'h1);
      g = 0;
      while (fpu_start !== 1'b1 && g < 50) begin @(negedge clk); g++; end
      s = cyc;
      g = 0;
      while (rsp_valid !== 1'b1 && g < 200) begin @(negedge clk); g++; end
      r = cyc;
      hang = 0;
      // WAIT holds for TIMEOUT cycles after the start cycle, then RESP
      n_total++;
      if (r - s !== TIMEOUT + 1) $display("FAIL timeout_latency: got %0d required %0d", r - s, TIMEOUT + 1);
      else n_pass++;
      check_rsp("timeout_rsp", rsp_data, rsp_err, rsp_opcode, '0, 1'b1, 2'b10);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      wait_rsp(ok, d, e, o);
      if (ok) check_rsp("after_timeout_rsp", d, e, o, 32'h2, 1'b0, 2'b00);
      n_total++;
      if (start_cnt - s0 !== 2) $display("FAIL timeout_starts: got %0d required 2", start_cnt - s0);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      bit ok; logic [W-1:0] d; logic e; logic [1:0] o, op; logic [W-1:0] a, b;
      logic [W-1:0] hd; logic he; int s0, g;
      fpu_lat = 2;
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         op = 2'($urandom_range(0, 2)); a = $urandom; b = $urandom_range(1, 1000);
         push_cmd(op, a, b);
         expect_rsp(op, a, b);
      end
      @(negedge clk);
      n_total++;
      if (cmd_ready !== 1'b0) $display("FAIL b2b_full: cmd_ready=%b required 0", cmd_ready);
      else n_pass++;
      // offer a sixth command while full; it must be dropped
      cmd_opcode = 2'b00; cmd_a = 32'hAAAA; cmd_b = 32'h5555; cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      g = 0;
      while (rsp_valid !== 1'b1 && g < 50) begin @(negedge clk); g++; end
      hd = rsp_data; he = rsp_err; s0 = start_cnt;
      n_total++;
      if (hd !== exp_q[0] || he !== exp_err_q[0]) $display("FAIL bp_first: data=%h err=%b required data=%h err=%b", hd, he, exp_q[0], exp_err_q[0]);
      else n_pass++;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         n_total++;
         if (rsp_valid !== 1'b1 || rsp_data !== hd || rsp_err !== he)
            $display("FAIL bp_hold_c%0d: valid=%b data=%h required valid=1 data=%h", k, rsp_valid, rsp_data, hd);
         else n_pass++;
      end
      n_total++;
      if (start_cnt !== s0) $display("FAIL bp_no_start: starts=%0d required 0", start_cnt - s0);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         wait_rsp(ok, d, e, o);
         if (ok) check_rsp($sformatf("b2b_rsp%0d", i), d, e, o, exp_q.pop_front(), exp_err_q.pop_front(), exp_op_q.pop_front());
      end
      repeat (30) @(negedge clk);
      n_total++;
      if (rsp_valid !== 1'b0) $display("FAIL b2b_dropped: rsp_valid=%b required 0", rsp_valid);
      else n_pass++;
      fpu_lat = 0;
   endtask

   task automatic test_random();
      int n_cmd, got, budget;
      n_cmd = 24; got = 0; budget = 0;
      fork
         begin
            logic [1:0] op; logic [W-1:0] a, b;
            for (int i = 0; i < n_cmd; i++) begin
               op = 2'($urandom_range(0, 3));
               a = $urandom;
               b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
               push_cmd(op, a, b);
               expect_rsp(op, a, b);
               repeat ($urandom_range(0, 3)) @(negedge clk);
            end
         end
         begin
            while (got < n_cmd && budget < 4000) begin
               @(negedge clk);
               budget++;
               rsp_ready = 1'($urandom_range(0, 1));
               if (rsp_valid && rsp_ready) begin
                  got++;
                  n_total++;
                  if (exp_q.size() == 0) $display("FAIL rand_rsp%0d: unexpected response data=%h", got, rsp_data);
                  else begin
                     logic [W-1:0] xd; logic xe; logic [1:0] xo;
                     xd = exp_q.pop_front(); xe = exp_err_q.pop_front(); xo = exp_op_q.pop_front();
                     if (rsp_data !== xd || rsp_err !== xe || rsp_opcode !== xo)
                        $display("FAIL rand_rsp%0d: data=%h err=%b op=%b required data=%h err=%b op=%b",
                                 got, rsp_data, rsp_err, rsp_opcode, xd, xe, xo);
                     else n_pass++;
                  end
               end
            end
            n_total++;
            if (got != n_cmd) $display("FAIL rand_count: got %0d required %0d", got, n_cmd);
            else n_pass++;
         end
      join
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid_wait();
      int g, s0, bad;
      hang = 1;
      push_cmd(2'b10, 32'h10, 32'h4);
      g = 0;
      while (fpu_start !== 1'b1 && g < 50) begin @(negedge clk); g++; end
      repeat (3) @(negedge clk);
      push_cmd(2'b00, 32'h5, 32'h6);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_total++;
      if ({rsp_valid, fpu_start, rsp_err, fpu_opcode, rsp_opcode, dbg_state} !== 9'b0 || fpu_a !== '0 || fpu_b !== '0 || rsp_data !== '0)
         $display("FAIL rst_mid_outputs: valid=%b start=%b a=%h op=%b state=%b required all 0", rsp_valid, fpu_start, fpu_a, fpu_opcode, dbg_state);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      hang = 0;
      s0 = start_cnt; bad = 0;
      repeat (30) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0) bad++;
      end
      n_total++;
      if (bad != 0 || start_cnt != s0)
         $display("FAIL rst_mid_quiet: rsp_valid cycles=%0d starts=%0d required 0 and 0", bad, start_cnt - s0);
      else n_pass++;
   endtask

   initial begin
      n_pass = 0; n_total = 0;
      test_reset();
      test_add();
      test_reserved();
      test_div0();
      test_timeout();
      test_back_to_back();
      test_random();
      test_reset_mid_wait();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
